// File: rtl/phi_monitor.sv
// -----------------------------------------------------------------------------
// phi_monitor
//
// Receiving end of the system clock interface. Takes the externally driven
// phi2 bus clock (asynchronous to fpga_clk), synchronises it, produces
// single-cycle rise/fall strobes, measures period and high time in fpga_clk
// cycles, and runs a lock state machine that reports whether phi2 stays
// within TOL cycles of the NOMINAL period.
//
// Parameters
//   SYNC_STAGES : synchroniser depth (>= 2)
//   CNT_W       : width of the cycle counter and the measurement outputs
//   NOMINAL     : expected phi2 period in fpga_clk cycles
//   TOL         : allowed deviation from NOMINAL (TOL < NOMINAL,
//                 NOMINAL+TOL < 2^CNT_W-1)
//   LOCK_COUNT  : consecutive good periods needed to lock (>= 1)
//
// Ports
//   fpga_clk  in   sole clock, all state on the rising edge
//   reset     in   asynchronous, active-high, clears all state
//   phi_in    in   external phi2, asynchronous
//   phi_sync  out  synchronised phi2 (last synchroniser stage)
//   rise      out  one-cycle strobe on a synchronised phi2 rising edge
//   fall      out  one-cycle strobe on a synchronised phi2 falling edge
//   period    out  last measured rise-to-rise time
//   high_time out  last measured rise-to-fall time
//   locked    out  phi2 within tolerance
//   err       out  one-cycle strobe on loss of lock
//   state_dbg out  current lock FSM state (0 idle, 1 acquire, 2 locked)
// -----------------------------------------------------------------------------
module phi_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int NOMINAL     = 50,
  parameter int TOL         = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             fpga_clk,
  input  logic             reset,
  input  logic             phi_in,
  output logic             phi_sync,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             err,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  localparam int GOOD_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_MAX - 1'b1;
  localparam logic [CNT_W-1:0]  GOOD_LO   = CNT_W'(NOMINAL - TOL);
  localparam logic [CNT_W-1:0]  GOOD_HI   = CNT_W'(NOMINAL + TOL);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  // fill_q[i] is set once sync_q[i] (and, for the top bit, prev_q) holds a
  // real sample of phi_in rather than the reset value. Edges are only
  // qualified once the edge-history flop is real, so that phi_in already
  // high at reset release does not look like a 0->1 transition.
  logic [SYNC_STAGES:0]   fill_q;
  logic                   prev_q;
  logic                   hist_valid;
  logic                   rise_d;
  logic                   fall_d;

  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   good_period;
  logic                   timeout;

  state_t                 state_q;
  state_t                 state_d;
  logic [GOOD_W-1:0]      good_q;
  logic [GOOD_W-1:0]      good_d;
  logic                   err_d;

  // ---------------------------------------------------------------------------
  // Synchroniser and edge detection
  // ---------------------------------------------------------------------------
  always_ff @(posedge fpga_clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], phi_in};
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign phi_sync   = sync_q[SYNC_STAGES-1];
  assign hist_valid = fill_q[SYNC_STAGES];
  assign rise_d     = hist_valid &  phi_sync & ~prev_q;
  assign fall_d     = hist_valid & ~phi_sync &  prev_q;

  // ---------------------------------------------------------------------------
  // Cycle counter
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (rise_d) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign good_period = (cnt_q >= GOOD_LO) && (cnt_q <= GOOD_HI);
  // Fires on the edge that takes cnt to saturation; a rise on that same
  // edge restarts the count instead, so the timeout is suppressed.
  assign timeout     = ~rise_d && (cnt_q == CNT_PRE);

  // ---------------------------------------------------------------------------
  // Lock state machine
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // First rise is only a reference; its period is not evaluated.
        if (rise_d) begin
          state_d = S_ACQUIRE;
          good_d  = '0;
        end
      end
      S_ACQUIRE: begin
        if (rise_d) begin
          if (good_period) begin
            good_d = good_q + 1'b1;
            if (good_q == GOOD_LAST) begin
              state_d = S_LOCKED;
            end
          end else begin
            good_d = '0;
          end
        end
      end
      S_LOCKED: begin
        if (rise_d && !good_period) begin
          err_d   = 1'b1;
          state_d = S_ACQUIRE;
          good_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        good_d  = '0;
      end
    endcase

    if (timeout) begin
      err_d   = (state_q == S_LOCKED);
      state_d = S_IDLE;
      good_d  = '0;
    end
  end

  always_ff @(posedge fpga_clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      good_q    <= '0;
      cnt_q     <= '0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      period    <= '0;
      high_time <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      cnt_q   <= cnt_d;
      rise    <= rise_d;
      fall    <= fall_d;
      // locked follows the state register so it changes on the same edge
      // as the rise strobe that caused the transition.
      locked  <= (state_d == S_LOCKED);
      err     <= err_d;
      if (rise_d) begin
        period <= cnt_q;
      end
      if (fall_d) begin
        high_time <= cnt_q;
      end
    end
  end

  assign state_dbg = state_q;

endmodule

// File: doc/phi_monitor.md
# phi_monitor

Receiving end of the system clock interface: takes an externally driven phi2 bus clock, asynchronous to `fpga_clk`, and makes it usable inside the FPGA. It synchronises the input, emits single-cycle rise and fall strobes, and measures period and high time in `fpga_clk` cycles. It also runs a lock state machine that reports whether phi2 is within tolerance of the nominal period. It sits between the host bus pins and the floppy controller logic, which qualifies bus accesses with `rise`/`fall` and gates operation on `locked`.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops (≥2).
- `CNT_W`, 8: width of cycle counter and measurement outputs.
- `NOMINAL`, 50: expected phi2 period in `fpga_clk` cycles.
- `TOL`, 2: allowed deviation in cycles; constraints `TOL < NOMINAL`, `NOMINAL+TOL < 2^CNT_W-1`.
- `LOCK_COUNT`, 4: consecutive good periods required to lock (≥1).

- `fpga_clk` in 1: sole clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `phi_in` in 1: external phi2, asynchronous.
- `phi_sync` out 1: synchronised phi2 (last synchroniser stage).
- `rise` out 1: one-cycle strobe on phi2 rising edge.
- `fall` out 1: one-cycle strobe on phi2 falling edge.
- `period` out CNT_W: last measured rise-to-rise period.
- `high_time` out CNT_W: last measured rise-to-fall time.
- `locked` out 1: phi2 within tolerance.
- `err` out 1: one-cycle strobe on loss of lock.

## Operation
- Reset values: synchroniser chain 0, edge-history flop 0, `phi_sync`=0, `rise`=0, `fall`=0, `period`=0, `high_time`=0, `locked`=0, `err`=0, counter `cnt`=0, good-period counter 0, state IDLE.
- Edge detect: `rise` registered from `phi_sync & ~prev`; `fall` registered from `~phi_sync & prev`. Never both asserted.
- Counter:
  - on rise: `period <= cnt`, `cnt <= 1`.
  - otherwise `cnt` increments, saturating at `2^CNT_W-1`.
  - on fall: `high_time <= cnt`; `cnt` keeps counting.
- Good period: `NOMINAL-TOL <= cnt <= NOMINAL+TOL`, unsigned, evaluated on `cnt` at the rise.
- States:
  - IDLE: no reference edge yet. First rise → ACQUIRE, good=0. This first `period` capture is not evaluated.
  - ACQUIRE, on rise:
    - good period: good+1; if good+1 == LOCK_COUNT → LOCKED.
    - bad period: good=0, stay in ACQUIRE.
  - LOCKED, on rise with bad period: `err` pulse, → ACQUIRE, good=0.
  - Timeout: `cnt` reaches saturation → IDLE, good=0. Also pulse `err` if the state was LOCKED.
- `locked` = registered (state == LOCKED).
- Simultaneous events:
  - rise in the same cycle `cnt` would saturate: the rise is processed and timeout is suppressed.
  - fall measurement is independent of state.
- Reset mid-operation: all outputs return to reset values within the same cycle, asynchronously. No strobe is generated on reset release even if `phi_in`=1; the first rise strobe needs a synchronised 0→1 transition after reset.

## Timing
- `phi_in` first sampled high at edge k → `phi_sync`=1 after edge k+SYNC_STAGES-1 → `rise`=1 after edge k+SYNC_STAGES, for exactly one cycle. `fall` has the same latency.
- `period`, `high_time`, `locked` and `err` update on the same edge that asserts the corresponding `rise`/`fall` strobe.
- The timeout `err` is asserted on the edge where `cnt` saturates.
- Measurements are exact for a clean input. Synchroniser uncertainty is ±1 cycle per edge, so a measured period may be ±1 cycle off.

## Test plan
- Reset then steady phi2, period 50, high 25: first rise gives `rise` 2 cycles after `phi_in` sampled high; `period`=50 from the 2nd rise onward; `high_time`=25; `locked`=1 on the 5th rise (1 reference + 4 good); `err` never asserted.
- Locked, then one period of 60: on that rise `period`=60, `err` pulses one cycle, `locked`=0. `locked` returns after 4 further 50-cycle periods.
- Tolerance edges: periods 48 and 52 count as good (lock achieved); periods 47 and 53 each reset the good count (no lock).
- Locked, then `phi_in` held low: `err` pulses and `locked`=0 exactly when `cnt` reaches 255. The state goes to IDLE, and the next rise does not count as a good period.
- `reset` asserted mid-period while locked: all outputs read 0 immediately. Releasing reset with `phi_in`=1 produces no `rise` until a 0→1 transition.
- 1-cycle glitch-free minimum pulses, phi2 period 4 with high time 2: `rise`/`fall` alternate correctly, `period`=4, `locked` stays 0.
